// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: digit data and blank mask in,
// encoder inputs, anode enables and frame marker out.
// master: the scan driver itself. slave: whoever supplies digits and
// consumes the scan outputs (encoder, display, testbench).
interface seg_scan_driver_if;
  logic [31:0] digits_in;
  logic [7:0]  blank_in;
  logic [3:0]  num;
  logic [3:0]  cdigit;
  logic [7:0]  an_out;
  logic        frame_start;

  modport master (
    input  digits_in, blank_in,
    output num, cdigit, an_out, frame_start
  );

  modport slave (
    output digits_in, blank_in,
    input  num, cdigit, an_out, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver.
// A prescaler sets the slot length; each slot opens with DEAD_CYCLES of all
// anodes off. Digits and blank mask are snapshotted once per frame on the
// slot 7 -> 0 edge, so a frame never mixes old and new data.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_driver #(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_driver_if.master   bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIM  = PW'(DEAD_CYCLES);

  logic [PW-1:0] presc_q,  presc_d;
  logic [2:0]    cdigit_q, cdigit_d;
  logic [3:0]    num_q,    num_d;
  logic [7:0]    an_q,     an_d;
  logic          fs_q,     fs_d;
  logic [31:0]   snap_d_q, snap_d_d;
  logic [7:0]    snap_b_q, snap_b_d;

  logic [7:0]    blank_eff;
  logic          tick;
  logic          snap_en;

  // Effective blank mask: external mask, optionally plus leading zeros
  always_comb begin
    blank_eff = bus.blank_in;
`ifdef SEG_SCAN_LZB_EN
    begin
      logic run;
      run = 1'b1;
      // Walk down from the leftmost digit; digit 0 always stays visible
      for (int d = 7; d >= 1; d--) begin
        if (run && (bus.digits_in[4*d +: 4] == 4'h0)) blank_eff[d] = 1'b1;
        else                                          run = 1'b0;
      end
    end
`endif
  end

  // Next-state: prescaler, digit index, frame snapshot and registered outputs
  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    snap_en  = tick && (cdigit_q == 3'd7);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cdigit_d = tick ? cdigit_q + 3'd1 : cdigit_q;
    snap_d_d = snap_en ? bus.digits_in : snap_d_q;
    snap_b_d = snap_en ? blank_eff     : snap_b_q;
    // Outputs look at the post-edge snapshot so slot 0 shows fresh data
    num_d    = snap_d_d[4*cdigit_d +: 4];
    if (((DEAD_CYCLES != 0) && (presc_d < DEAD_LIM)) || snap_b_d[cdigit_d])
      an_d = 8'hFF;
    else
      an_d = ~(8'h01 << cdigit_d);
    fs_d     = snap_en;
  end

  // State registers; reset parks on digit 7 so the first frame starts one slot later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      cdigit_q <= 3'd7;
      num_q    <= 4'h0;
      an_q     <= 8'hFF;
      fs_q     <= 1'b0;
      snap_d_q <= 32'h0;
      snap_b_q <= 8'hFF;
    end else begin
      presc_q  <= presc_d;
      cdigit_q <= cdigit_d;
      num_q    <= num_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
      snap_d_q <= snap_d_d;
      snap_b_q <= snap_b_d;
    end
  end

  assign bus.num         = num_q;
  assign bus.cdigit      = {1'b0, cdigit_q};
  assign bus.an_out      = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=4, DEAD_CYCLES=1).
// Reference model: with k = rising edges since reset release, the slot is
// k/SCAN_DIV, the digit is (7 + slot) mod 8, and a snapshot of the driven
// inputs is taken whenever k mod (8*SCAN_DIV) == SCAN_DIV.
module tb_seg_scan_driver;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int FRAME = 8 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          k      = 0;
  logic [31:0] m_d    = '0;
  logic [7:0]  m_b    = 8'hFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
  endtask

  // Leading-zero rule from the description: blank zeros from digit 7 down
  // until the first nonzero; digit 0 is never blanked by this rule.
  function automatic logic [7:0] eff_blank(input logic [31:0] d, input logic [7:0] b);
    logic [7:0] m;
    m = b;
`ifdef SEG_SCAN_LZB_EN
    begin
      int i;
      i = 7;
      while (i > 0 && ((d >> (4 * i)) & 32'hF) == 0) begin
        m[i] = 1'b1;
        i--;
      end
    end
`endif
    return m;
  endfunction

  task automatic check_all();
    int          dg;
    logic [7:0]  e_an;
    logic [3:0]  e_num;
    logic        e_fs;
    dg    = (7 + k / SD) % 8;
    e_num = 4'((m_d >> (4 * dg)) & 32'hF);
    e_an  = ((k % SD) < DC || m_b[dg]) ? 8'hFF : ~(8'h01 << dg);
    e_fs  = (k >= SD) && ((k % FRAME) == SD);
    chk("cdigit", 32'(bus.cdigit), 32'(dg));
    chk("num", 32'(bus.num), 32'(e_num));
    chk("an_out", 32'(bus.an_out), 32'(e_an));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
  endtask

  // One clock: model snapshot on the frame edge, then check at the falling edge
  task automatic step();
    @(posedge clk);
    k++;
    if ((k % FRAME) == SD) begin
      m_d = bus.digits_in;
      m_b = eff_blank(bus.digits_in, bus.blank_in);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"}, 32'(bus.an_out), 32'hFF);
    chk({tag, "_cdigit"}, 32'(bus.cdigit), 32'd7);
    chk({tag, "_num"}, 32'(bus.num), 32'd0);
    chk({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
  endtask

  // Assert reset between edges, check asynchronously, release at a falling edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_async");
    @(negedge clk);
    @(negedge clk);
    k   = 0;
    m_d = '0;
    m_b = 8'hFF;
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    bus.digits_in = 32'h12345678;
    bus.blank_in  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    check_all();

    // First frame_start exactly SCAN_DIV edges after release
    run(SD);
    chk("first_fs", 32'(bus.frame_start), 32'd1);
    chk("first_fs_digit", 32'(bus.cdigit), 32'd0);
    chk("first_num", 32'(bus.num), 32'h8);
    run(FRAME - 1);

    // Change data mid-frame (slot 3): current frame keeps old snapshot
    run(3 * SD + 1);
    bus.digits_in = 32'hABCDEF01;
    run(FRAME - 3 * SD - 1 + FRAME);

    // Low four digits blanked
    bus.blank_in = 8'h0F;
    run(2 * FRAME);

    // Leading-zero patterns
    bus.blank_in  = 8'h00;
    bus.digits_in = 32'h00000405;
    run(2 * FRAME);
    bus.digits_in = 32'h00000000;
    run(2 * FRAME);

    // Randomized inputs changing at arbitrary cycles
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.digits_in = $urandom();
        if ($urandom_range(0, 1) == 0) bus.digits_in &= 32'h0000FFFF;
      end
      if ($urandom_range(0, 15) == 0) bus.blank_in = 8'($urandom());
      step();
    end

    // Reset mid-slot 5, then a full fresh frame
    while ((k % FRAME) != SD + 5 * SD + 1) step();
    bus.digits_in = 32'h0BADCAFE;
    bus.blank_in  = 8'h00;
    do_reset();
    run(SD);
    chk("rst_fs", 32'(bus.frame_start), 32'd1);
    chk("rst_num", 32'(bus.num), 32'hE);
    run(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
